// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and counter sizing.
// Imported by the sequencer top and its testbench.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Wide enough to hold the larger of the two terminal counts with one spare bit.
  function automatic int cnt_width(input int lock_cycles, input int hold_cycles);
    int larger;
    if (lock_cycles > hold_cycles) begin
      larger = lock_cycles;
    end else begin
      larger = hold_cycles;
    end
    return $clog2(larger) + 32'sd1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
// Also intended for debouncing-path button inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the design in reset until PLL lock has been stable for a programmed time,
// then releases it synchronously; records lock drops seen after the stability check.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RESET_HOLD_CYCLES  = 8,
  parameter int LOSS_CNT_W         = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  soft_reset,
  output logic                  reset_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1'b1);

  logic                  lk_s;
  state_e                state_r;
  state_e                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic                  loss_s;
  logic                  reset_out_r;
  logic                  lock_lost_r;
  logic [LOSS_CNT_W-1:0] loss_count_r;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (pll_locked),
    .q      (lk_s)
  );

  // Next-state and counter logic; lock drop outranks soft_reset, which outranks counting.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    loss_s  = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (!lk_s) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_r == LOCK_LAST) begin
          state_s = HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_s = WAIT_LOCK;
          cnt_s   = CNT_ZERO;
          loss_s  = 1'b1;
        end else if (soft_reset) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_r == HOLD_LAST) begin
          state_s = RUN;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_s = WAIT_LOCK;
          cnt_s   = CNT_ZERO;
          loss_s  = 1'b1;
        end else if (soft_reset) begin
          state_s = HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = WAIT_LOCK;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output registers; reset_out tracks the next state so it
  // asserts on the very edge that leaves RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= WAIT_LOCK;
      cnt_r        <= CNT_ZERO;
      reset_out_r  <= 1'b1;
      lock_lost_r  <= 1'b0;
      loss_count_r <= {LOSS_CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      reset_out_r <= (state_s != RUN);
      lock_lost_r <= lock_lost_r | loss_s;
      if (loss_s && (loss_count_r != LOSS_MAX)) begin
        loss_count_r <= loss_count_r + LOSS_ONE;
      end else begin
        loss_count_r <= loss_count_r;
      end
    end
  end

  assign reset_out  = reset_out_r;
  assign ready      = ~reset_out_r;
  assign lock_lost  = lock_lost_r;
  assign loss_count = loss_count_r;

endmodule
